// File: rtl/out_port_4_serial_ctrl.sv
// Sequencer for output port 4's serial path.
// A start request produces one load pulse (Lo4). The block then paces shift-right pulses
// (shift_r) so that each data bit stays on serial_out for BAUD_DIV clocks, and pulses done
// when the frame is finished. It never handles WBUS data itself.
// Ports:
//   CLK      in   system clock, rising edge
//   CLR_n    in   asynchronous active-low reset
//   start    in   frame request, sampled only in IDLE
//   Lo4      out  load port 4 register (one-cycle pulse)
//   shift_r  out  shift port 4 register right (one-cycle pulse)
//   busy     out  high from the Lo4 cycle through the last cycle of the last bit
//   done     out  one-cycle pulse after the frame completes
//   bit_idx  out  index of the bit currently on serial_out, 0 when not in a bit
module out_port_4_serial_ctrl #(
    parameter int unsigned BAUD_DIV  = 4,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic       CLK,
    input  logic       CLR_n,
    input  logic       start,
    output logic       Lo4,
    output logic       shift_r,
    output logic       busy,
    output logic       done,
    output logic [2:0] bit_idx
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_BIT  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             lo4_q,     lo4_d;
    logic             shift_r_q, shift_r_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic [2:0]       bit_idx_q, bit_idx_d;

    // State and registered outputs
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q   <= S_IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            lo4_q     <= 1'b0;
            shift_r_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            lo4_q     <= lo4_d;
            shift_r_q <= shift_r_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // Next state, counters, and outputs decoded from the next state so they register in step
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d   = S_BIT;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
            S_BIT: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = S_DONE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase

        lo4_d     = (state_d == S_LOAD);
        busy_d    = (state_d == S_LOAD) || (state_d == S_BIT);
        done_d    = (state_d == S_DONE);
        // The last bit is never shifted out so it stays held on serial_out
        shift_r_d = (state_d == S_BIT) && (clk_cnt_d == CNT_LAST) && (bit_cnt_d != BIT_LAST);
        bit_idx_d = (state_d == S_BIT) ? 3'(bit_cnt_d) : 3'd0;
    end

    assign Lo4     = lo4_q;
    assign shift_r = shift_r_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_out_port_4_serial_ctrl.sv
// Bench for out_port_4_serial_ctrl: two instances (BAUD_DIV=4 and BAUD_DIV=1) share start
// and reset. The reference tracks each frame as "cycles since start sample" and derives
// every output from the frame timing rules. A port 4 register is emulated to read serial_out.
module tb_out_port_4_serial_ctrl;

    localparam int NB  = 8;
    localparam int BA  = 4;
    localparam int BB  = 1;

    logic       CLK = 1'b0;
    logic       CLR_n;
    logic       start;
    logic [7:0] wbus;

    logic       lo4_a, shr_a, busy_a, done_a;
    logic [2:0] idx_a;
    logic       lo4_b, shr_b, busy_b, done_b;
    logic [2:0] idx_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference frame position: 0 = idle, 1 = Lo4 cycle, ... 2+NB*B = done cycle
    int         t_a = 0;
    int         t_b = 0;
    logic [7:0] data_a = '0;
    logic [7:0] data_b = '0;
    logic [7:0] reg_a  = '0;
    logic [7:0] reg_b  = '0;

    always #5 CLK = ~CLK;

    out_port_4_serial_ctrl #(.BAUD_DIV(BA), .DATA_BITS(NB)) u_dut_a (
        .CLK(CLK), .CLR_n(CLR_n), .start(start),
        .Lo4(lo4_a), .shift_r(shr_a), .busy(busy_a), .done(done_a), .bit_idx(idx_a)
    );

    out_port_4_serial_ctrl #(.BAUD_DIV(BB), .DATA_BITS(NB)) u_dut_b (
        .CLK(CLK), .CLR_n(CLR_n), .start(start),
        .Lo4(lo4_b), .shift_r(shr_b), .busy(busy_b), .done(done_b), .bit_idx(idx_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {Lo4, shift_r, busy, done, bit_idx} at frame position t
    function automatic logic [6:0] exp_out(input int t, input int b, input int n);
        logic       lo, sh, bz, dn;
        logic [2:0] ix;
        lo = (t == 1);
        bz = (t >= 1) && (t <= 1 + n * b);
        dn = (t == 2 + n * b);
        sh = (t > 1) && ((t - 1) % b == 0) && ((t - 1) / b >= 1) && ((t - 1) / b <= n - 1);
        ix = (t >= 2 && t <= 1 + n * b) ? 3'((t - 2) / b) : 3'd0;
        return {lo, sh, bz, dn, ix};
    endfunction

    function automatic int next_t(input int t, input logic st, input int b, input int n);
        if (t == 0)         return st ? 1 : 0;
        if (t == 2 + n * b) return 0;
        return t + 1;
    endfunction

    always @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            t_a <= 0;
            t_b <= 0;
        end else begin
            t_a <= next_t(t_a, start, BA, NB);
            t_b <= next_t(t_b, start, BB, NB);
            if (t_a == 1) data_a <= wbus;
            if (t_b == 1) data_b <= wbus;
        end
    end

    // Emulated port 4 registers driven by the DUT strobes; serial_out is bit 0
    always @(posedge CLK) begin
        if (lo4_a)      reg_a <= wbus;
        else if (shr_a) reg_a <= reg_a >> 1;
        if (lo4_b)      reg_b <= wbus;
        else if (shr_b) reg_b <= reg_b >> 1;
    end

    // Cycle-by-cycle compare against the reference
    always @(negedge CLK) begin
        if (CLR_n === 1'b1) begin
            logic [6:0] ea, eb;
            ea = exp_out(t_a, BA, NB);
            eb = exp_out(t_b, BB, NB);
            check("outs_a", {25'd0, lo4_a, shr_a, busy_a, done_a, idx_a}, {25'd0, ea});
            check("outs_b", {25'd0, lo4_b, shr_b, busy_b, done_b, idx_b}, {25'd0, eb});
            if (t_a >= 2 && t_a <= 1 + NB * BA)
                check("serial_a", {31'd0, reg_a[0]}, {31'd0, data_a[ea[2:0]]});
            if (t_b >= 2 && t_b <= 1 + NB * BB)
                check("serial_b", {31'd0, reg_b[0]}, {31'd0, data_b[eb[2:0]]});
        end
    end

    task automatic idle(input int n);
        start = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    // One frame from a single start pulse; optional re-pulses at C10 and C34 must be ignored
    task automatic run_frame(input logic [7:0] w, input bit repulse);
        logic [7:0] bits_a, bits_b;
        int         cyc, done_cyc_a, done_cyc_b, dones_a;
        bits_a = '0; bits_b = '0;
        done_cyc_a = 0; done_cyc_b = 0; dones_a = 0;
        @(negedge CLK); #1; wbus = w; start = 1'b1;
        @(negedge CLK);
        cyc = 1;
        while (cyc <= 45) begin
            if (cyc >= 2 && (cyc - 2) % BA == 0 && (cyc - 2) / BA < NB)
                bits_a[(cyc - 2) / BA] = reg_a[0];
            if (cyc >= 2 && (cyc - 2) / BB < NB)
                bits_b[(cyc - 2) / BB] = reg_b[0];
            if (done_a === 1'b1) begin
                dones_a++;
                if (done_cyc_a == 0) done_cyc_a = cyc;
            end
            if (done_b === 1'b1 && done_cyc_b == 0) done_cyc_b = cyc;
            #1;
            start = (repulse && (cyc == 10 || cyc == 34)) ? 1'b1 : 1'b0;
            @(negedge CLK);
            cyc++;
        end
        start = 1'b0;
        check("done_cycle_a", done_cyc_a, 34);
        check("done_cycle_b", done_cyc_b, 10);
        check("bits_a", {24'd0, bits_a}, {24'd0, w});
        check("bits_b", {24'd0, bits_b}, {24'd0, w});
        check("done_count_a", dones_a, 1);
        idle(15);
    endtask

    initial begin
        int first_lo, second_lo, cyc;
        CLR_n = 1'b0;
        start = 1'b0;
        wbus  = 8'h00;

        // Reference pinned by hand-derived frame timing
        check("model_lo4_c1",   {25'd0, exp_out(1, BA, NB)},  {25'd0, 7'b1010000});
        check("model_shr_c29",  {25'd0, exp_out(29, BA, NB)}, {25'd0, 7'b0110110});
        check("model_busy_c33", {25'd0, exp_out(33, BA, NB)}, {25'd0, 7'b0010111});
        check("model_done_c34", {25'd0, exp_out(34, BA, NB)}, {25'd0, 7'b0001000});
        check("model_b1_c9",    {25'd0, exp_out(9, BB, NB)},  {25'd0, 7'b0010111});
        check("model_b1_c10",   {25'd0, exp_out(10, BB, NB)}, {25'd0, 7'b0001000});

        repeat (3) @(negedge CLK);
        check("reset_outs", {18'd0, lo4_a, shr_a, busy_a, done_a, idx_a,
                             lo4_b, shr_b, busy_b, done_b, idx_b}, 32'd0);
        #2 CLR_n = 1'b1;
        idle(6);

        run_frame(8'hA5, 1'b0);
        run_frame(8'h81, 1'b0);
        run_frame(8'h5A, 1'b1);

        // Start held high: back-to-back frames, Lo4 every 35 cycles
        @(negedge CLK); #1; start = 1'b1;
        first_lo = -1; second_lo = -1; cyc = 0;
        while (cyc < 120 && second_lo < 0) begin
            @(negedge CLK);
            cyc++;
            if (lo4_a === 1'b1) begin
                if (first_lo < 0) first_lo = cyc;
                else              second_lo = cyc;
            end
        end
        check("held_lo4_spacing", second_lo - first_lo, 35);
        #1; start = 1'b0;
        idle(45);

        // Reset in the middle of a frame, then a clean frame
        @(negedge CLK); #1; start = 1'b1;
        @(negedge CLK); #1; start = 1'b0;
        repeat (14) @(negedge CLK);
        #2 CLR_n = 1'b0;
        #1 check("midframe_reset", {26'd0, busy_a, shr_a, done_a, busy_b, shr_b, done_b}, 32'd0);
        #1 CLR_n = 1'b1;
        idle(5);
        run_frame(8'h3C, 1'b0);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 299) == 0) begin
                #2 CLR_n = 1'b0;
                #1 check("rand_reset", {25'd0, lo4_a, shr_a, busy_a, done_a, idx_a}, 32'd0);
                #1 CLR_n = 1'b1;
            end else begin
                #1;
                start = ($urandom_range(0, 3) == 0);
                wbus  = 8'($urandom);
            end
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
